// File: rtl/mcu_sequencer.sv
// mcu_sequencer
// Control side of the MCU mux array. It walks a column-major frame through
// LOAD -> PROC -> OUT. On each pass the ring of N+2 column memories rotates
// by N columns.
//
// Ports
//   i_CLK, i_rst_n         clock (rising edge) and asynchronous active-low reset
//   i_start                frame start pulse, sampled only in IDLE
//   i_valid / o_ready      host pixel handshake during LOAD
//   o_valid / i_ready      result handshake during OUT
//   o_state                mux state: 00 LOAD, 01 PROC, 10 OUT, 11 IDLE
//   o_substate             ring position index k
//   o_memSelect            memory addressed during LOAD and OUT
//   o_rd_en, o_rd_addr     shared read strobe and address
//   o_wr_en, o_wr_addr     per-memory write enables and shared write address
//   o_busy, o_done         high outside IDLE; one-cycle pulse at frame end
//
// Build option: define MCU_SEQ_AUTOSTART_EN to leave IDLE automatically.
// Without it, every frame needs an i_start pulse.
module mcu_sequencer #(
   parameter int N        = 2,
   parameter int IMG_ROWS = 64,
   parameter int IMG_COLS = 66,
   parameter int ADDR_W   = 6,
   parameter int PIPE_LAT = 3,
   localparam int SUB_W   = ($clog2((N + 2) / 2) > 0) ? $clog2((N + 2) / 2) : 1,
   localparam int SEL_W   = $clog2(N + 1)
) (
   input  logic               i_CLK,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic               i_valid,
   output logic               o_ready,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [1:0]         o_state,
   output logic [SUB_W-1:0]   o_substate,
   output logic [SEL_W-1:0]   o_memSelect,
   output logic               o_rd_en,
   output logic [ADDR_W-1:0]  o_rd_addr,
   output logic [N+1:0]       o_wr_en,
   output logic [ADDR_W-1:0]  o_wr_addr,
   output logic               o_busy,
   output logic               o_done
);

   localparam int CYC_W  = $clog2(IMG_ROWS + PIPE_LAT + 1);
   localparam int BEAT_W = $clog2(N * IMG_ROWS + 1);
   localparam int PCOL_W = $clog2(IMG_COLS + 1);

   localparam logic [SEL_W:0]    MEMS_W         = (SEL_W + 1)'(N + 2);
   localparam logic [ADDR_W-1:0] ROW_LAST       = ADDR_W'(IMG_ROWS - 1);
   localparam logic [SEL_W-1:0]  COL_LAST_FIRST = SEL_W'(N + 1);
   localparam logic [SEL_W-1:0]  COL_LAST       = SEL_W'(N - 1);
   localparam logic [SEL_W-1:0]  COL_COUNT      = SEL_W'(N);
   localparam logic [CYC_W-1:0]  CYC_RD_END     = CYC_W'(IMG_ROWS);
   localparam logic [CYC_W-1:0]  CYC_WR_START   = CYC_W'(PIPE_LAT);
   localparam logic [CYC_W-1:0]  CYC_WR_END     = CYC_W'(PIPE_LAT + IMG_ROWS);
   localparam logic [CYC_W-1:0]  CYC_LAST       = CYC_W'(IMG_ROWS + PIPE_LAT - 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST      = BEAT_W'(N * IMG_ROWS - 1);
   localparam logic [PCOL_W-1:0] PCOL_TOTAL     = PCOL_W'(IMG_COLS - 2);
   localparam logic [SUB_W-1:0]  SUB_LAST       = SUB_W'((N + 2) / 2 - 1);

   typedef enum logic [1:0] {
      ST_LOAD = 2'b00,
      ST_PROC = 2'b01,
      ST_OUT  = 2'b10,
      ST_IDLE = 2'b11
   } state_t;

   state_t              state_q, state_d;
   logic                first_q, first_d;
   logic [ADDR_W-1:0]   row_q, row_d;
   logic [SEL_W-1:0]    col_q, col_d;
   logic [CYC_W-1:0]    cyc_q, cyc_d;
   logic [ADDR_W-1:0]   issueRow_q, issueRow_d;
   logic [SEL_W-1:0]    issueCol_q, issueCol_d;
   logic [BEAT_W-1:0]   accept_q, accept_d;
   logic                valid_q, valid_d;
   logic [SEL_W-1:0]    outSel_q, outSel_d;
   logic [SEL_W-1:0]    procBase_q, procBase_d;
   logic [SEL_W-1:0]    loadBase_q, loadBase_d;
   logic [SUB_W-1:0]    sub_q, sub_d;
   logic [PCOL_W-1:0]   processed_q, processed_d;
   logic                done_q, done_d;

   logic                startReq;
   logic                issueNow;
   logic [SEL_W-1:0]    loadSel;
   logic [N+1:0]        procMask;

   // Ring arithmetic: memory index (base + offset) mod (N+2).
   function automatic logic [SEL_W-1:0] wrapSel(input logic [SEL_W-1:0] base,
                                                input logic [SEL_W-1:0] offset);
      logic [SEL_W:0] sum;
      sum = {1'b0, base} + {1'b0, offset};
      if (sum >= MEMS_W) begin
         sum = sum - MEMS_W;
      end
      return sum[SEL_W-1:0];
   endfunction

`ifdef MCU_SEQ_AUTOSTART_EN
   assign startReq = 1'b1;
`else
   assign startReq = i_start;
`endif

   // procBase_q is the ring base (k*N) mod (N+2) for the current PROC/OUT pass.
   // loadBase_q is the base of the columns that were just emitted. Later
   // LOAD phases refill exactly those columns.
   assign loadSel = first_q ? col_q : wrapSel(loadBase_q, col_q);

   // PROC writes conv results into the N memories of the current ring position.
   always_comb begin
      procMask = '0;
      for (int m = 0; m < N; m++) begin
         procMask[wrapSel(procBase_q, SEL_W'(m))] = 1'b1;
      end
   end

   assign o_state    = state_q;
   assign o_substate = sub_q;
   assign o_busy     = (state_q != ST_IDLE);
   assign o_done     = done_q;

   // Next-state and output decode. In OUT, a new read is issued whenever the
   // output register is empty or is being drained this cycle. The beat's
   // memory select is registered together with o_valid. This keeps it stable
   // under backpressure.
   always_comb begin
      state_d     = state_q;
      first_d     = first_q;
      row_d       = row_q;
      col_d       = col_q;
      cyc_d       = cyc_q;
      issueRow_d  = issueRow_q;
      issueCol_d  = issueCol_q;
      accept_d    = accept_q;
      valid_d     = valid_q;
      outSel_d    = outSel_q;
      procBase_d  = procBase_q;
      loadBase_d  = loadBase_q;
      sub_d       = sub_q;
      processed_d = processed_q;
      done_d      = 1'b0;
      issueNow    = 1'b0;
      o_ready     = 1'b0;
      o_valid     = 1'b0;
      o_memSelect = '0;
      o_rd_en     = 1'b0;
      o_rd_addr   = '0;
      o_wr_en     = '0;
      o_wr_addr   = '0;

      case (state_q)
         ST_IDLE: begin
            if (startReq) begin
               state_d     = ST_LOAD;
               first_d     = 1'b1;
               row_d       = '0;
               col_d       = '0;
               cyc_d       = '0;
               issueRow_d  = '0;
               issueCol_d  = '0;
               accept_d    = '0;
               valid_d     = 1'b0;
               outSel_d    = '0;
               procBase_d  = '0;
               loadBase_d  = '0;
               sub_d       = '0;
               processed_d = '0;
            end
         end

         ST_LOAD: begin
            o_ready     = 1'b1;
            o_memSelect = loadSel;
            if (i_valid) begin
               o_wr_en[loadSel] = 1'b1;
               o_wr_addr        = row_q;
               if (row_q == ROW_LAST) begin
                  row_d = '0;
                  if (col_q == (first_q ? COL_LAST_FIRST : COL_LAST)) begin
                     col_d   = '0;
                     cyc_d   = '0;
                     state_d = ST_PROC;
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end

         ST_PROC: begin
            if (cyc_q < CYC_RD_END) begin
               o_rd_en   = 1'b1;
               o_rd_addr = ADDR_W'(cyc_q);
            end
            if ((cyc_q >= CYC_WR_START) && (cyc_q < CYC_WR_END)) begin
               o_wr_en   = procMask;
               o_wr_addr = ADDR_W'(cyc_q - CYC_WR_START);
            end
            if (cyc_q == CYC_LAST) begin
               state_d     = ST_OUT;
               processed_d = processed_q + PCOL_W'(N);
               issueRow_d  = '0;
               issueCol_d  = '0;
               accept_d    = '0;
               valid_d     = 1'b0;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end

         ST_OUT: begin
            o_valid     = valid_q;
            o_memSelect = outSel_q;
            issueNow    = (issueCol_q != COL_COUNT) && (!valid_q || i_ready);
            o_rd_en     = issueNow;
            if (issueNow) begin
               o_rd_addr = issueRow_q;
               valid_d   = 1'b1;
               outSel_d  = wrapSel(procBase_q, issueCol_q);
               if (issueRow_q == ROW_LAST) begin
                  issueRow_d = '0;
                  issueCol_d = issueCol_q + 1'b1;
               end else begin
                  issueRow_d = issueRow_q + 1'b1;
               end
            end else if (i_ready) begin
               valid_d = 1'b0;
            end
            if (valid_q && i_ready) begin
               if (accept_q == BEAT_LAST) begin
                  valid_d = 1'b0;
                  if (processed_q < PCOL_TOTAL) begin
                     state_d    = ST_LOAD;
                     first_d    = 1'b0;
                     row_d      = '0;
                     col_d      = '0;
                     loadBase_d = procBase_q;
                     procBase_d = wrapSel(procBase_q, COL_COUNT);
                     sub_d      = (sub_q == SUB_LAST) ? '0 : sub_q + 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  accept_d = accept_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register. Reset returns to IDLE at once. The column memories live
   // outside this block, so their contents survive the reset.
   always_ff @(posedge i_CLK or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         first_q     <= 1'b0;
         row_q       <= '0;
         col_q       <= '0;
         cyc_q       <= '0;
         issueRow_q  <= '0;
         issueCol_q  <= '0;
         accept_q    <= '0;
         valid_q     <= 1'b0;
         outSel_q    <= '0;
         procBase_q  <= '0;
         loadBase_q  <= '0;
         sub_q       <= '0;
         processed_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         first_q     <= first_d;
         row_q       <= row_d;
         col_q       <= col_d;
         cyc_q       <= cyc_d;
         issueRow_q  <= issueRow_d;
         issueCol_q  <= issueCol_d;
         accept_q    <= accept_d;
         valid_q     <= valid_d;
         outSel_q    <= outSel_d;
         procBase_q  <= procBase_d;
         loadBase_q  <= loadBase_d;
         sub_q       <= sub_d;
         processed_q <= processed_d;
         done_q      <= done_d;
      end
   end

endmodule
